// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: assembles 3-byte commands from a UART receiver (MSB first)
// and sends 16-bit responses as two bytes through a UART transmitter.
// The RX and TX sides are independent FSMs; every output is a flop.
module uart_cmd_ctrl #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  input  logic        tx_done,
  output logic        trmt,
  output logic [7:0]  tx_data,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        cmd_ovr,
  input  logic [15:0] resp_data,
  input  logic        send_resp,
  output logic        resp_busy,
  output logic        resp_sent
);

  // Gap counter only has to reach TIMEOUT_CYC-1.
  localparam int GW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {RX_B0, RX_B1, RX_B2} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_HI, TX_WAIT_HI, TX_LO, TX_WAIT_LO} tx_state_t;

  rx_state_t   rx_state_q, rx_state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]  byte0_q, byte0_d;
  logic [7:0]  byte1_q, byte1_d;
  logic [23:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        cmd_ovr_q, cmd_ovr_d;
  logic        clr_rx_rdy_q, clr_rx_rdy_d;
  logic        rx_take;
  logic        cmd_done;

  tx_state_t   tx_state_q, tx_state_d;
  logic [15:0] resp_q, resp_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        trmt_q, trmt_d;
  logic        resp_busy_q, resp_busy_d;
  logic        resp_sent_q, resp_sent_d;

  // RX next-state: byte capture, gap timeout, command completion flags.
  // A byte arriving on the timeout cycle is still accepted.
  always_comb begin
    rx_state_d   = rx_state_q;
    gap_d        = gap_q;
    byte0_d      = byte0_q;
    byte1_d      = byte1_q;
    cmd_d        = cmd_q;
    cmd_done     = 1'b0;
    rx_take      = rx_rdy & ~clr_rx_rdy_q;
    clr_rx_rdy_d = rx_take;
    case (rx_state_q)
      RX_B0: begin
        gap_d = '0;
        if (rx_take) begin
          byte0_d    = rx_data;
          rx_state_d = RX_B1;
        end
      end
      RX_B1: begin
        if (rx_take) begin
          byte1_d    = rx_data;
          gap_d      = '0;
          rx_state_d = RX_B2;
        end else if (gap_q == GAP_LAST) begin
          gap_d      = '0;
          rx_state_d = RX_B0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      RX_B2: begin
        if (rx_take) begin
          cmd_d      = {byte0_q, byte1_q, rx_data};
          cmd_done   = 1'b1;
          gap_d      = '0;
          rx_state_d = RX_B0;
        end else if (gap_q == GAP_LAST) begin
          gap_d      = '0;
          rx_state_d = RX_B0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        gap_d      = '0;
        rx_state_d = RX_B0;
      end
    endcase
    // Completion beats a simultaneous host clear.
    cmd_rdy_d = cmd_done | (cmd_rdy_q & ~clr_cmd_rdy);
    cmd_ovr_d = (cmd_done & cmd_rdy_q) | (cmd_ovr_q & ~clr_cmd_rdy);
  end

  // TX next-state: high byte then low byte; trmt_q high marks the first
  // wait cycle, during which the stale tx_done level is ignored.
  always_comb begin
    tx_state_d  = tx_state_q;
    resp_d      = resp_q;
    tx_data_d   = tx_data_q;
    trmt_d      = 1'b0;
    resp_sent_d = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (send_resp) begin
          resp_d     = resp_data;
          tx_state_d = TX_HI;
        end
      end
      TX_HI: begin
        trmt_d     = 1'b1;
        tx_data_d  = resp_q[15:8];
        tx_state_d = TX_WAIT_HI;
      end
      TX_WAIT_HI: begin
        if (!trmt_q && tx_done) tx_state_d = TX_LO;
      end
      TX_LO: begin
        trmt_d     = 1'b1;
        tx_data_d  = resp_q[7:0];
        tx_state_d = TX_WAIT_LO;
      end
      TX_WAIT_LO: begin
        if (!trmt_q && tx_done) begin
          resp_sent_d = 1'b1;
          tx_state_d  = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    resp_busy_d = (tx_state_d != TX_IDLE);
  end

  // RX state and command registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q   <= RX_B0;
      gap_q        <= '0;
      byte0_q      <= '0;
      byte1_q      <= '0;
      cmd_q        <= '0;
      cmd_rdy_q    <= 1'b0;
      cmd_ovr_q    <= 1'b0;
      clr_rx_rdy_q <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      gap_q        <= gap_d;
      byte0_q      <= byte0_d;
      byte1_q      <= byte1_d;
      cmd_q        <= cmd_d;
      cmd_rdy_q    <= cmd_rdy_d;
      cmd_ovr_q    <= cmd_ovr_d;
      clr_rx_rdy_q <= clr_rx_rdy_d;
    end
  end

  // TX state and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      resp_q      <= '0;
      tx_data_q   <= '0;
      trmt_q      <= 1'b0;
      resp_busy_q <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      resp_q      <= resp_d;
      tx_data_q   <= tx_data_d;
      trmt_q      <= trmt_d;
      resp_busy_q <= resp_busy_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  assign clr_rx_rdy = clr_rx_rdy_q;
  assign cmd        = cmd_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign cmd_ovr    = cmd_ovr_q;
  assign trmt       = trmt_q;
  assign tx_data    = tx_data_q;
  assign resp_busy  = resp_busy_q;
  assign resp_sent  = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Testbench for uart_cmd_ctrl: directed stimulus, scoreboard queues popped
// by a monitor whenever the DUT presents a command, a trmt or a resp_sent.
module tb_uart_cmd_ctrl;

  localparam int TO = 20;

  logic        clk, rst;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        tx_done;
  logic        trmt;
  logic [7:0]  tx_data;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        cmd_ovr;
  logic [15:0] resp_data;
  logic        send_resp;
  logic        resp_busy;
  logic        resp_sent;

  uart_cmd_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
    .tx_done(tx_done), .trmt(trmt), .tx_data(tx_data),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .cmd_ovr(cmd_ovr),
    .resp_data(resp_data), .send_resp(send_resp),
    .resp_busy(resp_busy), .resp_sent(resp_sent)
  );

  int n_vec = 0;
  int n_bad = 0;
  int clr_cnt = 0;
  int exp_sent = 0;
  logic [23:0] exp_cmd[$];
  logic [7:0]  exp_tx[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Transmitter model: busy 10 cycles per byte after each trmt.
  initial begin
    int cnt;
    tx_done = 1'b1;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_done = 1'b1;
        cnt = 0;
      end else if (trmt) begin
        tx_done = 1'b0;
        cnt = 10;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) tx_done = 1'b1;
      end
    end
  end

  // Monitor: pops expected values when the DUT presents an output event.
  initial begin
    logic [23:0] prev_cmd;
    logic [23:0] e_cmd;
    logic [7:0]  e_tx;
    logic [7:0]  last_tx;
    logic        prev_rdy, prev_trmt, prev_clr;
    prev_cmd = '0; prev_rdy = 0; prev_trmt = 0; prev_clr = 0; last_tx = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_cmd = cmd; prev_rdy = cmd_rdy; prev_trmt = 0; prev_clr = 0; last_tx = '0;
      end else begin
        if (cmd !== prev_cmd || (cmd_rdy && !prev_rdy)) begin
          if (exp_cmd.size() == 0) begin
            chk("cmd_unexpected", cmd, 24'hFFFFFF);
          end else begin
            e_cmd = exp_cmd.pop_front();
            chk("cmd_value", cmd, e_cmd);
            chk("cmd_rdy_with_cmd", cmd_rdy, 1);
          end
        end
        if (clr_rx_rdy) begin
          clr_cnt++;
          chk("clr_rx_rdy_width", prev_clr, 0);
        end
        if (trmt) begin
          chk("trmt_width", prev_trmt, 0);
          if (exp_tx.size() == 0) begin
            chk("trmt_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
          end else begin
            e_tx = exp_tx.pop_front();
            chk("tx_data", tx_data, e_tx);
          end
          last_tx = tx_data;
        end else if (tx_data !== last_tx) begin
          chk("tx_data_stable", tx_data, last_tx);
          last_tx = tx_data;
        end
        if (resp_sent) begin
          chk("resp_sent_expected", (exp_sent > 0), 1);
          if (exp_sent > 0) exp_sent--;
        end
        prev_cmd = cmd; prev_rdy = cmd_rdy; prev_trmt = trmt; prev_clr = clr_rx_rdy;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit clr);
    @(negedge clk);
    rx_rdy = 1'b1;
    rx_data = b;
    clr_cmd_rdy = clr;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    chk("clr_rx_rdy_ack", clr_rx_rdy, 1);
    rx_rdy = 1'b0;
  endtask

  task automatic send_cmd(input logic [23:0] c);
    exp_cmd.push_back(c);
    send_byte(c[23:16], 0);
    send_byte(c[15:8], 0);
    send_byte(c[7:0], 0);
  endtask

  task automatic host_clr();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_trmt(input string name);
    int k = 0;
    while (!trmt && k < 50) begin @(negedge clk); k++; end
    chk(name, trmt, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_rdy = 0; rx_data = '0; clr_cmd_rdy = 0;
    resp_data = '0; send_resp = 0;
    idle(2);
    chk("rst_cmd", cmd, 0);
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_trmt", trmt, 0);
    chk("rst_resp_busy", resp_busy, 0);
    rst = 1'b0;
    idle(2);

    // Basic command with three handshakes
    clr_cnt = 0;
    send_cmd(24'hA5123C);
    idle(2);
    chk("three_clr_pulses", clr_cnt, 3);
    chk("cmd_rdy_after_cmd", cmd_rdy, 1);
    chk("cmd_ovr_after_cmd", cmd_ovr, 0);
    host_clr();
    chk("cmd_rdy_cleared", cmd_rdy, 0);
    chk("cmd_hold", cmd, 24'hA5123C);

    // Inter-byte timeout discards partial command
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    idle(TO + 5);
    send_cmd(24'h334455);
    idle(1);
    chk("cmd_ovr_after_timeout", cmd_ovr, 0);
    host_clr();

    // Gap just under the limit keeps the command intact
    exp_cmd.push_back(24'h667788);
    send_byte(8'h66, 0);
    idle(TO - 5);
    send_byte(8'h77, 0);
    idle(TO - 5);
    send_byte(8'h88, 0);
    host_clr();

    // Overwrite without consumption
    send_cmd(24'h010203);
    send_cmd(24'h040506);
    idle(1);
    chk("ovr_cmd", cmd, 24'h040506);
    chk("ovr_flag", cmd_ovr, 1);
    chk("ovr_rdy", cmd_rdy, 1);
    host_clr();
    chk("ovr_cleared_rdy", cmd_rdy, 0);
    chk("ovr_cleared_flag", cmd_ovr, 0);

    // Completion coincident with host clear: set wins
    send_cmd(24'h070809);
    exp_cmd.push_back(24'h0A0B0C);
    send_byte(8'h0A, 0);
    send_byte(8'h0B, 0);
    send_byte(8'h0C, 1);
    chk("set_wins_rdy", cmd_rdy, 1);
    chk("set_wins_ovr", cmd_ovr, 1);
    host_clr();
    chk("set_wins_cleared", cmd_rdy, 0);

    // Response transmission, concurrent with RX traffic
    exp_tx.push_back(8'hBE);
    exp_tx.push_back(8'hEF);
    exp_sent++;
    @(negedge clk);
    resp_data = 16'hBEEF;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    resp_data = 16'h0000;
    fork
      begin
        int k;
        wait_trmt("trmt_hi_seen");
        idle(2);
        chk("busy_during_tx", resp_busy, 1);
        resp_data = 16'h1234;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        k = 0;
        while (!resp_sent && k < 100) begin @(negedge clk); k++; end
        chk("resp_sent_seen", resp_sent, 1);
        chk("busy_after_sent", resp_busy, 0);
      end
      begin
        idle(3);
        send_cmd(24'hC0FFEE);
      end
    join
    idle(40);
    chk("no_extra_busy", resp_busy, 0);
    host_clr();

    // Reset in TX_WAIT_HI and RX_B1
    exp_tx.push_back(8'hCA);
    @(negedge clk);
    resp_data = 16'hCAFE;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    wait_trmt("trmt_before_rst");
    send_byte(8'h5A, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cmd", cmd, 0);
    chk("mid_rst_cmd_rdy", cmd_rdy, 0);
    chk("mid_rst_cmd_ovr", cmd_ovr, 0);
    chk("mid_rst_clr_rx_rdy", clr_rx_rdy, 0);
    chk("mid_rst_trmt", trmt, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_resp_busy", resp_busy, 0);
    chk("mid_rst_resp_sent", resp_sent, 0);
    idle(2);
    rst = 1'b0;
    idle(40);
    chk("post_rst_cmd_rdy", cmd_rdy, 0);
    chk("post_rst_busy", resp_busy, 0);
    send_cmd(24'hDEAD01);
    idle(2);
    chk("post_rst_cmd", cmd, 24'hDEAD01);

    idle(5);
    chk("exp_cmd_left", exp_cmd.size(), 0);
    chk("exp_tx_left", exp_tx.size(), 0);
    chk("exp_sent_left", exp_sent, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 50000, max clk cycles allowed between bytes of one command.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx_rdy  input  1  receiver holds a valid byte.
REQ-005 SHALL have port rx_data  input  8  received byte.
REQ-006 SHALL have port clr_rx_rdy  output  1  one-cycle pulse that consumes the receiver byte.
REQ-007 SHALL have port tx_done  input  1  transmitter idle/finished level; clears on trmt.
REQ-008 SHALL have port trmt  output  1  one-cycle pulse that starts a byte transmission.
REQ-009 SHALL have port tx_data  output  8  byte to transmit.
REQ-010 SHALL have port cmd  output  24  last complete command.
REQ-011 SHALL have port cmd_rdy  output  1  cmd valid and not yet consumed.
REQ-012 SHALL have port clr_cmd_rdy  input  1  host consumes cmd.
REQ-013 SHALL have port cmd_ovr  output  1  sticky: a command was overwritten before consumption.
REQ-014 SHALL have port resp_data  input  16  response word sampled on send_resp.
REQ-015 SHALL have port send_resp  input  1  request to transmit resp_data.
REQ-016 SHALL have port resp_busy  output  1  response transmission in progress.
REQ-017 SHALL have port resp_sent  output  1  one-cycle pulse when both response bytes are done.

Function
REQ-018 SHALL implement the RX FSM with states RX_B0, RX_B1 and RX_B2 (bytes 0..2 expected); it starts in RX_B0.
REQ-019 SHALL, when rx_rdy=1 in cycle N and clr_rx_rdy=0, capture rx_data, assert clr_rx_rdy in cycle N+1 only, and advance the state; rx_rdy is ignored while clr_rx_rdy=1.
REQ-020 SHALL use byte order MSB first: byte0 -> cmd[23:16], byte1 -> [15:8], byte2 -> [7:0].
REQ-021 SHALL update cmd and set cmd_rdy=1 at the edge that captures byte2, then return to RX_B0; cmd is unchanged otherwise.
REQ-022 SHALL clear cmd_rdy at the edge on which clr_cmd_rdy=1 is sampled; if a command completes in the same cycle, set wins.
REQ-023 SHALL set cmd_ovr when a command completes while cmd_rdy=1; cmd_ovr clears only with clr_cmd_rdy (set wins).
REQ-024 SHALL run a gap counter that resets on each captured byte and increments in RX_B1/RX_B2; on reaching TIMEOUT_CYC-1 the FSM returns to RX_B0 and discards the partial bytes; cmd and cmd_rdy are unaffected.
REQ-025 SHALL implement the TX FSM with states TX_IDLE, TX_HI, TX_WAIT_HI, TX_LO and TX_WAIT_LO.
REQ-026 SHALL, in TX_IDLE on send_resp=1, latch resp_data and go to TX_HI; send_resp in any other state is ignored.
REQ-027 SHALL, in TX_HI, pulse trmt for one cycle with tx_data=resp[15:8], then enter TX_WAIT_HI.
REQ-028 SHALL, in TX_WAIT_HI, ignore tx_done in the first cycle, then on tx_done=1 go to TX_LO.
REQ-029 SHALL, in TX_LO, pulse trmt with tx_data=resp[7:0]; TX_WAIT_LO follows the same rule as REQ-028; on completion pulse resp_sent for one cycle and return to TX_IDLE.
REQ-030 SHALL keep tx_data stable from each trmt pulse until the next trmt pulse.
REQ-031 SHALL drive resp_busy=1 in all TX states except TX_IDLE.
REQ-032 SHALL run the RX and TX FSMs independently and concurrently; neither FSM stalls the other.
REQ-033 SHALL drive all outputs directly from registers.

Reset
REQ-034 SHALL, on rst=1 and asynchronously, force RX_B0 and TX_IDLE, clear the gap counter, and set cmd=0, cmd_rdy=0, cmd_ovr=0, clr_rx_rdy=0, trmt=0, tx_data=0, resp_busy=0 and resp_sent=0.
REQ-035 SHALL abandon any partial command and any in-flight response on reset mid-operation, with no trmt or resp_sent pulse after reset release until a new send_resp.

Verification
REQ-036 SHALL cover: bytes 0xA5, 0x12, 0x3C with rx_rdy handshakes -> cmd=0xA5123C, cmd_rdy=1, and exactly three clr_rx_rdy pulses.
REQ-037 SHALL cover: bytes 0x11, 0x22, then no byte for TIMEOUT_CYC cycles, then 0x33, 0x44, 0x55 -> cmd=0x334455.
REQ-038 SHALL cover: two full commands with no clr_cmd_rdy in between -> cmd holds the second command, cmd_ovr=1; then clr_cmd_rdy -> cmd_rdy=0 and cmd_ovr=0.
REQ-039 SHALL cover: send_resp with resp_data=0xBEEF, tx_done model of 10 cycles per byte -> trmt with 0xBE, then trmt with 0xEF, then one resp_sent pulse; a second send_resp while busy is ignored.
REQ-040 SHALL cover: rst asserted in TX_WAIT_HI and in RX_B1 -> all outputs at reset values immediately, with no spurious trmt or cmd_rdy afterward.
REQ-041 SHALL cover: a command completing in the same cycle as clr_cmd_rdy=1 -> cmd_rdy=1 afterward.
